box_drawer: RTL and testbench

BOX_DRAWER -- requirements
Module: box_drawer

---
 rtl/box_drawer_if.sv | 25 ++
 rtl/box_drawer.sv | 112 +++++++++++
 tb/tb_box_drawer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/box_drawer_if.sv
// Box request handshake and VGA pixel-write bus for box_drawer.
// The master drives box requests; the slave (the drawer) drives s_ready and the pixel bus.
interface box_drawer_if;
    logic       s_valid;
    logic       s_ready;
    logic [8:0] in_box_x;
    logic [8:0] in_box_y;
    logic [8:0] in_box_w;
    logic [8:0] in_box_h;
    logic [2:0] in_box_color;
    logic [8:0] vga_x;
    logic [8:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;

    modport master (
        output s_valid, in_box_x, in_box_y, in_box_w, in_box_h, in_box_color,
        input  s_ready, vga_x, vga_y, vga_color, vga_plot
    );

    modport slave (
        input  s_valid, in_box_x, in_box_y, in_box_w, in_box_h, in_box_color,
        output s_ready, vga_x, vga_y, vga_color, vga_plot
    );
endinterface

// File: rtl/box_drawer.sv
// Rasterises a filled rectangle one pixel per cycle in row-major order,
// clipping pixels that fall outside the visible screen.
module box_drawer #(
    parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
    parameter logic [8:0] SCREEN_HEIGHT = 9'd240
) (
    input  logic          clock,
    input  logic          reset_n,
    box_drawer_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t     r_state;
    logic [8:0] r_x;
    logic [8:0] r_y;
    logic [8:0] r_w;
    logic [8:0] r_h;
    logic [2:0] r_color;
    logic [8:0] r_col;
    logic [8:0] r_row;
    logic [8:0] r_vga_x;
    logic [8:0] r_vga_y;
    logic [2:0] r_vga_color;
    logic       r_vga_plot;

    logic [9:0] w_px_x;
    logic [9:0] w_px_y;
    logic       w_visible;
    logic       w_last_col;
    logic       w_last_row;

    // 10-bit sums so a box hanging past column/row 511 cannot alias back on screen
    assign w_px_x     = {1'b0, r_x} + {1'b0, r_col};
    assign w_px_y     = {1'b0, r_y} + {1'b0, r_row};
    assign w_visible  = (w_px_x < {1'b0, SCREEN_WIDTH}) && (w_px_y < {1'b0, SCREEN_HEIGHT});
    assign w_last_col = (r_col == (r_w - 9'd1));
    assign w_last_row = (r_row == (r_h - 9'd1));

    assign bus.s_ready   = (r_state == S_IDLE);
    assign bus.vga_x     = r_vga_x;
    assign bus.vga_y     = r_vga_y;
    assign bus.vga_color = r_vga_color;
    assign bus.vga_plot  = r_vga_plot;

    // Accept/draw state machine with registered pixel outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_x         <= 9'd0;
            r_y         <= 9'd0;
            r_w         <= 9'd0;
            r_h         <= 9'd0;
            r_color     <= 3'd0;
            r_col       <= 9'd0;
            r_row       <= 9'd0;
            r_vga_x     <= 9'd0;
            r_vga_y     <= 9'd0;
            r_vga_color <= 3'd0;
            r_vga_plot  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vga_plot <= 1'b0;
                    if (bus.s_valid) begin
                        r_x     <= bus.in_box_x;
                        r_y     <= bus.in_box_y;
                        r_w     <= bus.in_box_w;
                        r_h     <= bus.in_box_h;
                        r_color <= bus.in_box_color;
                        r_col   <= 9'd0;
                        r_row   <= 9'd0;
                        // Degenerate boxes are consumed without drawing
                        if ((bus.in_box_w != 9'd0) && (bus.in_box_h != 9'd0)) begin
                            r_state <= S_DRAW;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAW: begin
                    r_vga_x     <= w_px_x[8:0];
                    r_vga_y     <= w_px_y[8:0];
                    r_vga_color <= r_color;
                    r_vga_plot  <= w_visible;
                    if (w_last_col) begin
                        r_col <= 9'd0;
                        if (w_last_row) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_row   <= r_row + 9'd1;
                            r_state <= S_DRAW;
                        end
                    end else begin
                        r_col   <= r_col + 9'd1;
                        r_state <= S_DRAW;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_vga_plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_box_drawer.sv
// Scoreboard bench for box_drawer: a driver pushes every expected pixel (with its
// cycle stamp) from a raster model; an independent monitor pops and compares.
module tb_box_drawer;

    localparam int SW = 320;
    localparam int SH = 240;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } px_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    px_t  exp_q[$];

    box_drawer_if bus ();

    box_drawer dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: sampled at the negedge it equals the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every plotted pixel must match the head of the expected queue
    always @(negedge clk) begin
        if (bus.vga_plot === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d at cycle %0d, required no plot",
                         bus.vga_x, bus.vga_y, bus.vga_color, cyc);
            end else begin
                px_t e;
                e = exp_q.pop_front();
                if (bus.vga_x != e.x || bus.vga_y != e.y || bus.vga_color != e.c || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL pixel: got (%0d,%0d) c=%0d cycle %0d, required (%0d,%0d) c=%0d cycle %0d",
                             bus.vga_x, bus.vga_y, bus.vga_color, cyc, e.x, e.y, e.c, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic drive_junk();
        bus.s_valid      = 1'($urandom_range(0, 1));
        bus.in_box_x     = 9'($urandom);
        bus.in_box_y     = 9'($urandom);
        bus.in_box_w     = 9'($urandom);
        bus.in_box_h     = 9'($urandom);
        bus.in_box_color = 3'($urandom);
    endtask

    // Push the visible pixels of a box accepted at edge acc; keep only the first lim
    task automatic model_box(input int x, input int y, input int w, input int h,
                             input int c, input int acc, input int lim);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                int idx;
                idx = r * w + k;
                if (idx < lim && (x + k) < SW && (y + r) < SH) begin
                    exp_q.push_back('{x + k, y + r, c, acc + 1 + idx});
                end
            end
        end
    endtask

    // Called at a negedge with s_ready expected high; returns at the negedge where it is high again
    task automatic send_box(input int x, input int y, input int w, input int h, input int c);
        int acc;
        int n;
        bus.s_valid      = 1'b1;
        bus.in_box_x     = 9'(x);
        bus.in_box_y     = 9'(y);
        bus.in_box_w     = 9'(w);
        bus.in_box_h     = 9'(h);
        bus.in_box_color = 3'(c);
        @(negedge clk);
        acc = cyc;
        n   = w * h;
        model_box(x, y, w, h, c, acc, n);
        check("ready_after_accept", int'(bus.s_ready), (n == 0) ? 1 : 0);
        for (int i = 1; i <= n; i++) begin
            drive_junk();
            @(negedge clk);
            if (i == n || i == 1) begin
                check("ready_during_box", int'(bus.s_ready), (i == n) ? 1 : 0);
            end
        end
    endtask

    task automatic idle_cycles(input int g);
        for (int i = 0; i < g; i++) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
            check("ready_idle", int'(bus.s_ready), 1);
        end
    endtask

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus.s_valid      = 1'b0;
        bus.in_box_x     = 9'd0;
        bus.in_box_y     = 9'd0;
        bus.in_box_w     = 9'd0;
        bus.in_box_h     = 9'd0;
        bus.in_box_color = 3'd0;
        #1;
        check("reset_plot",  int'(bus.vga_plot),  0);
        check("reset_x",     int'(bus.vga_x),     0);
        check("reset_y",     int'(bus.vga_y),     0);
        check("reset_color", int'(bus.vga_color), 0);
        check("reset_ready", int'(bus.s_ready),   1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed boxes: basic raster, corner clipping, zero width, back-to-back pair
        send_box(10, 20, 3, 2, 5);
        idle_cycles(2);
        send_box(318, 238, 4, 3, 6);
        send_box(40, 40, 0, 5, 1);
        send_box(7, 9, 2, 2, 3);
        send_box(100, 100, 1, 1, 2);
        send_box(101, 100, 2, 1, 4);
        send_box(50, 50, 5, 0, 7);
        idle_cycles(1);
        // Long rows and clipped bands exercise the full 9-bit counters and 10-bit sums
        send_box(300, 5, 511, 2, 1);
        send_box(0, 237, 320, 3, 0);
        send_box(511, 511, 2, 2, 3);

        // Randomised boxes with random idle gaps
        for (int t = 0; t < 60; t++) begin
            int w;
            int h;
            w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
            send_box(int'($urandom_range(0, 330)), int'($urandom_range(0, 250)), w, h,
                     int'($urandom_range(0, 7)));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // Asynchronous reset mid-box: plot must drop at once and the rest of the box is abandoned
        bus.s_valid      = 1'b1;
        bus.in_box_x     = 9'd50;
        bus.in_box_y     = 9'd60;
        bus.in_box_w     = 9'd8;
        bus.in_box_h     = 9'd8;
        bus.in_box_color = 3'd6;
        @(negedge clk);
        model_box(50, 60, 8, 8, 6, cyc, 5);
        bus.s_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("plot_before_reset", int'(bus.vga_plot), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("plot_async_reset",  int'(bus.vga_plot), 0);
        check("ready_async_reset", int'(bus.s_ready),  1);
        @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(20);
        send_box(3, 4, 2, 2, 5);
        idle_cycles(3);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
